pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the single-bit full adder: WIDTH-bit add/subtract with carry-in, split into STAGES equal chunks, one chunk resolved per clock stage.
- Valid/ready streaming handshake on input and output. A stalled output holds the whole pipeline.
- Sits in the datapath library as the building block for accumulators and address generators.

---
 rtl/pipelined_adder.sv | 135 +++++++++++++
 tb/tb_pipelined_adder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
//==============================================================================
// Module   : pipelined_adder
// Brief    : WIDTH-bit add/subtract with carry-in, one CW-bit chunk resolved per
//            stage, valid/ready handshake with global stall.
//            Optional SIGNED_OVF_EN adds the registered two's-complement ovf port.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic adv;

  // Stage k holds: operands (chunks above k still pending), sum chunks 0..k,
  // carry out of chunk k and the slot's valid bit.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic             v_d [STAGES];

  logic [WIDTH-1:0] w_src_a [STAGES];
  logic [WIDTH-1:0] w_src_b [STAGES];
  logic [WIDTH-1:0] w_src_s [STAGES];
  logic             w_src_c [STAGES];
  logic             w_src_v [STAGES];
  logic [CW:0]      w_chunk;

  assign adv      = !v_q[LAST] || out_ready;
  assign in_ready = adv;

  always_comb begin
    w_src_a[0] = a;
    w_src_b[0] = sub ? ~b : b;
    w_src_s[0] = '0;
    w_src_c[0] = sub ? 1'b1 : cin;
    w_src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_src_a[k] = a_q[k-1];
      w_src_b[k] = b_q[k-1];
      w_src_s[k] = s_q[k-1];
      w_src_c[k] = c_q[k-1];
      w_src_v[k] = v_q[k-1];
    end
  end

  always_comb begin
    w_chunk = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_chunk = {1'b0, w_src_a[k][k*CW +: CW]} + {1'b0, w_src_b[k][k*CW +: CW]}
              + {{CW{1'b0}}, w_src_c[k]};
      a_d[k]               = w_src_a[k];
      b_d[k]               = w_src_b[k];
      s_d[k]               = w_src_s[k];
      s_d[k][k*CW +: CW]   = w_chunk[CW-1:0];
      c_d[k]               = w_chunk[CW];
      v_d[k]               = w_src_v[k];
    end
  end

`ifdef SIGNED_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign ovf_d = (w_src_a[LAST][WIDTH-1] ^ w_src_b[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1])
               ^ c_d[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign carry     = c_q[LAST];

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
//==============================================================================
// Module   : tb_pipelined_adder
// Brief    : Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry;
`ifdef SIGNED_OVF_EN
  logic        ovf;
`endif

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
`ifdef SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] s;
    int          cyc;
  } log_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  exp_t  exp_q[$];
  log_t  out_log[$];
  bit    prev_stall = 1'b0;
  logic [15:0] prev_sum;
  logic        prev_carry;
  bit    last_acc;
  vec_t  tbl[9];

  task automatic check(input bit ok, input string nm, input logic [31:0] got,
                       input logic [31:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mcin, input logic msub);
    exp_t e;
    int   sa, sb, r;
    logic [16:0] t;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      e.s = ma - mb;
      e.c = (ma >= mb);
      r   = sa - sb;
    end else begin
      t   = {1'b0, ma} + {1'b0, mb} + {16'd0, mcin};
      e.s = t[15:0];
      e.c = t[16];
      r   = sa + sb + int'(mcin);
    end
    e.o   = (r > 32767) || (r < -32768);
    e.cyc = cyc;
    return e;
  endfunction

  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic icin, input logic isub, input logic iordy);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = icin;
    sub       = isub;
    out_ready = iordy;
    #1;
    cyc++;
    if (prev_stall)
      check(out_valid === 1'b1 && sum === prev_sum && carry === prev_carry,
            "stall_hold", {15'd0, carry, sum}, {15'd0, prev_carry, prev_sum});
    check(in_ready === !(out_valid && !out_ready), "in_ready", in_ready,
          !(out_valid && !out_ready));
    last_acc = iv && in_ready;
    if (last_acc) exp_q.push_back(model(ia, ib, icin, isub));
    if (out_valid && out_ready) begin
      check(exp_q.size() != 0, "sb_unexpected", {16'd0, sum}, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(sum === e.s, "sb_sum", sum, e.s);
        check(carry === e.c, "sb_carry", carry, e.c);
`ifdef SIGNED_OVF_EN
        check(ovf === e.o, "sb_ovf", ovf, e.o);
`endif
      end
      out_log.push_back('{s: sum, cyc: cyc});
    end
    prev_stall = out_valid && !out_ready;
    prev_sum   = sum;
    prev_carry = carry;
  endtask

  task automatic wait_out(input logic iordy, output int lat);
    lat = 0;
    do begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, iordy);
      lat++;
    end while (!out_valid && lat < 12);
    check(out_valid === 1'b1, "wait_out_timeout", out_valid, 1);
  endtask

  initial begin
    int lat;
    int i;
    int t;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0};
    tbl[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
    tbl[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    tbl[8] = '{16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
    check(sum === 16'h0, "rst_sum", sum, 0);
    check(carry === 1'b0, "rst_carry", carry, 0);
    check(in_ready === 1'b1, "rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, one beat at a time, with latency check.
    for (int k = 0; k < 9; k++) begin
      step(1'b1, tbl[k].a, tbl[k].b, tbl[k].cin, tbl[k].sub, 1'b1);
      wait_out(1'b1, lat);
      check(lat == 4, "latency", lat, 4);
      check(sum === tbl[k].s, "tbl_sum", sum, tbl[k].s);
      check(carry === tbl[k].c, "tbl_carry", carry, tbl[k].c);
    end

`ifdef SIGNED_OVF_EN
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_out(1'b1, lat);
    check(sum === 16'h8000, "ovf_sum", sum, 16'h8000);
    check(ovf === 1'b1, "ovf_flag", ovf, 1);
`endif

    // Back-pressure: 8 beats, out_ready low for 6 cycles mid-stream.
    out_log.delete();
    i = 1;
    t = 0;
    while ((i <= 8 || exp_q.size() != 0) && t < 80) begin
      step(i <= 8, 16'(i), 16'(i), 1'b0, 1'b0, !(t >= 5 && t < 11));
      if (last_acc) i++;
      t++;
    end
    check(out_log.size() == 8, "bp_count", out_log.size(), 8);
    for (int k = 0; k < out_log.size() && k < 8; k++)
      check(out_log[k].s === 16'(2 * (k + 1)), "bp_order", out_log[k].s, 2 * (k + 1));

    // Bubbles: in_valid 1,0,1,0,0,1 -> 3 results with spacing 2 then 3.
    out_log.delete();
    step(1'b1, 16'd10, 16'd1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'd20, 16'd2, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'd30, 16'd3, 1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    check(out_log.size() == 3, "bubble_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      check(out_log[1].cyc - out_log[0].cyc == 2, "bubble_gap1",
            out_log[1].cyc - out_log[0].cyc, 2);
      check(out_log[2].cyc - out_log[1].cyc == 3, "bubble_gap2",
            out_log[2].cyc - out_log[1].cyc, 3);
    end

    // Reset mid-operation with 3 beats in flight and output stalled.
    out_log.delete();
    for (int k = 0; k < 3; k++) step(1'b1, 16'(16'h0100 + k), 16'h0011, 1'b1, 1'b0, 1'b0);
    wait_out(1'b0, lat);
    #2 rst_n = 1'b0;
    #1;
    check(out_valid === 1'b0, "mid_rst_valid", out_valid, 0);
    check(sum === 16'h0, "mid_rst_sum", sum, 0);
    check(carry === 1'b0, "mid_rst_carry", carry, 0);
    check(in_ready === 1'b1, "mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    check(out_log.size() == 0, "no_stale", out_log.size(), 0);
    step(1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
    wait_out(1'b1, lat);
    check(lat == 4, "post_rst_latency", lat, 4);
    check(sum === 16'd2, "post_rst_sum", sum, 2);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7);
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      t++;
    end
    check(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
